firebird_regfile: RTL and testbench

- RV32I integer register file, 32 x 32 bit, directly upstream of the ALU.
- Read ports rs1/rs2 drive alu_data1 and the register operand of alu_data2 (via the imm mux) in the same cycle.
- The write port takes the writeback value (ALU result or load data) at the rising clock edge.
- Also provides a debug read port and a retired-write counter for bring-up and verification.

---
 rtl/firebird_regfile_pkg.sv | 18 +
 rtl/firebird_regfile_if.sv | 29 ++
 rtl/firebird_regfile_rdport.sv | 33 +++
 rtl/firebird_regfile.sv | 69 ++++++
 tb/tb_firebird_regfile.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/firebird_regfile_pkg.sv
// Shared RV32I register-file types, used by decode, ALU and the register file.
// Address and data widths are fixed by the integer ISA.
package firebird_pkg;

    localparam int XLEN       = 32;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    function automatic logic wr_commit(input logic en, input reg_addr_t addr);
        return en && (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/firebird_regfile_if.sv
// Register-file bus: two operand read ports, one debug read port, the
// writeback port and the committed-write counter.
interface firebird_regfile_if #(
    parameter int CNT_W = 32
);
    import firebird_pkg::*;

    reg_addr_t        rs1_addr;
    xlen_t            rs1_data;
    reg_addr_t        rs2_addr;
    xlen_t            rs2_data;
    logic             wr_en;
    reg_addr_t        wr_addr;
    xlen_t            wr_data;
    reg_addr_t        dbg_addr;
    xlen_t            dbg_data;
    logic [CNT_W-1:0] wr_count;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, dbg_addr,
        input  rs1_data, rs2_data, dbg_data, wr_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, dbg_addr,
        output rs1_data, rs2_data, dbg_data, wr_count
    );

endinterface

// File: rtl/firebird_regfile_rdport.sv
// One combinational read port with the x0 rule and optional write forwarding.
// Forwarding is compiled in by FIREBIRD_REGFILE_BYPASS_EN.
module firebird_regfile_rdport
    import firebird_pkg::*;
(
    input  reg_addr_t addr_i,
    input  xlen_t     regs_i [REG_NUM],
    input  logic      byp_en_i,
    input  logic      wr_en_i,
    input  reg_addr_t wr_addr_i,
    input  xlen_t     wr_data_i,
    output xlen_t     data_o
);

`ifndef FIREBIRD_REGFILE_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{byp_en_i, wr_en_i, wr_addr_i, wr_data_i};
`endif

    always_comb begin
        data_o = regs_i[addr_i];
`ifdef FIREBIRD_REGFILE_BYPASS_EN
        if (byp_en_i && wr_en_i && (wr_addr_i == addr_i)) begin
            data_o = wr_data_i;
        end
`endif
        // x0 wins over forwarding as well as over stored state
        if (addr_i == ZERO_REG) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/firebird_regfile.sv
// RV32I integer register file, 32 x 32, with debug port and write counter.
// Optional same-cycle forwarding on rs1/rs2: FIREBIRD_REGFILE_BYPASS_EN.
module firebird_regfile
    import firebird_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    firebird_regfile_if.slave bus
);

    xlen_t            regs_q [REG_NUM];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             commit;
    logic             byp_wr_en;

    assign commit = wr_commit(bus.wr_en, bus.wr_addr);
    assign cnt_d  = cnt_q + CNT_W'(1);

    // A write seen during reset must not leak through the forward path
    assign byp_wr_en = bus.wr_en & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (commit) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
            cnt_q               <= cnt_d;
        end
    end

    assign bus.wr_count = cnt_q;

    firebird_regfile_rdport u_rs1 (
        .addr_i    (bus.rs1_addr),
        .regs_i    (regs_q),
        .byp_en_i  (1'b1),
        .wr_en_i   (byp_wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .data_o    (bus.rs1_data)
    );

    firebird_regfile_rdport u_rs2 (
        .addr_i    (bus.rs2_addr),
        .regs_i    (regs_q),
        .byp_en_i  (1'b1),
        .wr_en_i   (byp_wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .data_o    (bus.rs2_data)
    );

    firebird_regfile_rdport u_dbg (
        .addr_i    (bus.dbg_addr),
        .regs_i    (regs_q),
        .byp_en_i  (1'b0),
        .wr_en_i   (byp_wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .data_o    (bus.dbg_data)
    );

endmodule

// File: tb/tb_firebird_regfile.sv
// Scoreboard bench for firebird_regfile: a 32-bit-counter instance plus a
// CNT_W=4 instance used to exercise counter wrap.
module tb_firebird_regfile;
    import firebird_pkg::*;

`ifdef FIREBIRD_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    firebird_regfile_if #(.CNT_W(32)) bus ();
    firebird_regfile_if #(.CNT_W(4))  busw ();

    firebird_regfile #(.CNT_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    firebird_regfile #(.CNT_W(4)) u_dutw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return bus.rs1_data;
            1:       return bus.rs2_data;
            2:       return bus.dbg_data;
            3:       return bus.wr_count;
            4:       return 32'(busw.wr_count);
            default: return busw.rs1_data;
        endcase
    endfunction

    // Monitor: outputs are combinational, so every cycle with pending
    // expectations is a sample point, taken on the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = pick(e.sel);
                checks++;
                if (act !== e.val) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic expect_v(input int sel, input logic [31:0] v, input string n);
        exp_t e;
        e.sel  = sel;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input reg_addr_t wa, input xlen_t wd,
                       input reg_addr_t a1, input reg_addr_t a2, input reg_addr_t ad);
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        bus.dbg_addr = ad;
    endtask

    initial begin
        logic [31:0] cnt;
        rst_n = 1'b0;
        drv(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
        busw.wr_en    = 1'b0;
        busw.wr_addr  = 5'd0;
        busw.wr_data  = '0;
        busw.rs1_addr = 5'd0;
        busw.rs2_addr = 5'd0;
        busw.dbg_addr = 5'd0;
        repeat (2) step();

        // write attempted while reset held is discarded
        drv(1'b1, 5'd3, 32'h0BAD_0BAD, 5'd3, 5'd3, 5'd3);
        expect_v(0, 32'h0, "rst_hold_rs1");
        expect_v(2, 32'h0, "rst_hold_dbg");
        expect_v(3, 32'h0, "rst_hold_cnt");
        step();
        rst_n = 1'b1;
        drv(1'b0, 5'd0, '0, 5'd3, 5'd3, 5'd3);
        expect_v(0, 32'h0, "rst_discard_rs1");
        step();

        for (int i = 0; i < 32; i++) begin
            drv(1'b0, 5'd0, '0, 5'(i), 5'(31 - i), 5'(i));
            expect_v(0, 32'h0, $sformatf("init_rs1_x%0d", i));
            expect_v(1, 32'h0, $sformatf("init_rs2_x%0d", 31 - i));
            expect_v(2, 32'h0, $sformatf("init_dbg_x%0d", i));
            step();
        end
        expect_v(3, 32'h0, "init_cnt");
        cnt = 0;

        drv(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        step();
        cnt++;
        drv(1'b0, 5'd0, '0, 5'd5, 5'd5, 5'd5);
        expect_v(0, 32'hDEAD_BEEF, "x5_rs1");
        expect_v(1, 32'hDEAD_BEEF, "x5_rs2");
        expect_v(2, 32'hDEAD_BEEF, "x5_dbg");
        expect_v(3, cnt, "x5_cnt");
        step();

        // x0 write, also never forwarded
        drv(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        expect_v(0, 32'h0, "x0_same_rs1");
        expect_v(1, 32'h0, "x0_same_rs2");
        step();
        drv(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
        expect_v(0, 32'h0, "x0_rs1");
        expect_v(2, 32'h0, "x0_dbg");
        expect_v(3, cnt, "x0_cnt");
        step();

        drv(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0, 5'd0);
        step();
        cnt++;
        drv(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 5'd7);
        expect_v(0, BYP ? 32'h2222_2222 : 32'h1111_1111, "coll_rs1");
        expect_v(1, BYP ? 32'h2222_2222 : 32'h1111_1111, "coll_rs2");
        expect_v(2, 32'h1111_1111, "coll_dbg");
        expect_v(3, cnt, "coll_cnt");
        step();
        cnt++;
        drv(1'b0, 5'd0, '0, 5'd7, 5'd7, 5'd7);
        expect_v(0, 32'h2222_2222, "x7_rs1");
        expect_v(1, 32'h2222_2222, "x7_rs2");
        expect_v(2, 32'h2222_2222, "x7_dbg");
        expect_v(3, cnt, "x7_cnt");
        step();

        drv(1'b1, 5'd31, 32'hA5A5_A5A5, 5'd0, 5'd0, 5'd0);
        step();
        cnt++;
        drv(1'b0, 5'd0, '0, 5'd31, 5'd31, 5'd31);
        expect_v(0, 32'hA5A5_A5A5, "x31_rs1");
        expect_v(3, cnt, "x31_cnt");
        step();

        // asynchronous reset mid-cycle with a write pending
        rst_n = 1'b0;
        drv(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, 5'd31);
        expect_v(0, 32'h0, "arst_rs1");
        expect_v(1, 32'h0, "arst_rs2");
        expect_v(2, 32'h0, "arst_dbg");
        expect_v(3, 32'h0, "arst_cnt");
        step();
        rst_n = 1'b1;
        cnt = 0;
        drv(1'b1, 5'd9, 32'hCAFE_F00D, 5'd31, 5'd0, 5'd5);
        expect_v(0, 32'h0, "post_rst_x31");
        expect_v(2, 32'h0, "post_rst_x5");
        step();
        cnt++;
        drv(1'b0, 5'd0, '0, 5'd9, 5'd9, 5'd9);
        expect_v(1, 32'hCAFE_F00D, "first_wr_rs2");
        expect_v(3, cnt, "first_wr_cnt");
        step();

        // 4-bit counter wraps after 16 writes to x1
        for (int i = 0; i < 16; i++) begin
            busw.wr_en   = 1'b1;
            busw.wr_addr = 5'd1;
            busw.wr_data = 32'(i + 1);
            expect_v(4, 32'(i), $sformatf("wrap_cnt_%0d", i));
            step();
        end
        busw.wr_en    = 1'b0;
        busw.rs1_addr = 5'd1;
        expect_v(4, 32'h0, "wrap_cnt_final");
        expect_v(5, 32'h10, "wrap_x1");
        step();

        repeat (2) step();
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
